// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo: 4-entry byte FIFO feeding an 8N1 RS232 transmitter.
//
// Ports:
//   CLK           system clock, all logic on the rising edge
//   RST           synchronous active-high reset
//   SendData      byte to enqueue, qualified by SendDataReady
//   SendDataReady one-cycle write strobe
//   TXD           registered serial output, idle high
//   TX_BUSY       high while bytes are queued or a frame is on the line
//   FIFO_FULL     high when four bytes are stored
//   FIFO_COUNT    number of stored bytes, 0..4
//   OVERFLOW      sticky, set when a write is dropped on a full FIFO
module rs232_tx_fifo #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SendData,
  input  logic       SendDataReady,
  output logic       TXD,
  output logic       TX_BUSY,
  output logic       FIFO_FULL,
  output logic [2:0] FIFO_COUNT,
  output logic       OVERFLOW
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [7:0]  mem [4];
  logic [1:0]  wrPtr;
  logic [1:0]  rdPtr;
  logic [2:0]  count;
  txState_t    state;
  txState_t    stateNext;
  logic [15:0] baudCnt;
  logic [2:0]  bitCnt;
  logic [2:0]  nextBit;
  logic [7:0]  shiftReg;
  logic        txdReg;
  logic        txdNext;
  logic        overflowReg;
  logic        pop;
  logic        push;
  logic        baudDone;

  assign baudDone = (baudCnt == BAUD_LAST);
  assign nextBit  = bitCnt + 3'd1;
  // A full FIFO still accepts a write when the transmitter pops in the same cycle.
  assign push     = SendDataReady && ((count != 3'd4) || pop);

  always_comb begin
    stateNext = state;
    txdNext   = txdReg;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txdNext = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          txdNext   = 1'b0;
          stateNext = START;
        end
      end
      START: begin
        if (baudDone) begin
          stateNext = DATA;
          txdNext   = shiftReg[0];
        end
      end
      DATA: begin
        if (baudDone) begin
          if (bitCnt == 3'd7) begin
            stateNext = STOP;
            txdNext   = 1'b1;
          end else begin
            txdNext = shiftReg[nextBit];
          end
        end
      end
      STOP: begin
        if (baudDone) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        txdNext   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem[wrPtr] <= SendData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      txdReg      <= 1'b1;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      baudCnt     <= '0;
      bitCnt      <= '0;
      overflowReg <= 1'b0;
    end else begin
      txdReg <= txdNext;

      if (push) begin
        wrPtr <= wrPtr + 2'd1;
      end

      if (pop) begin
        shiftReg <= mem[rdPtr];
        rdPtr    <= rdPtr + 2'd1;
        bitCnt   <= '0;
      end else if ((state == DATA) && baudDone) begin
        bitCnt <= nextBit;
      end

      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      if (SendDataReady && !push) begin
        overflowReg <= 1'b1;
      end

      // Restart the bit timer on every state change and at each bit boundary.
      if ((state == IDLE) || (stateNext != state) || baudDone) begin
        baudCnt <= '0;
      end else begin
        baudCnt <= baudCnt + 16'd1;
      end
    end
  end

  assign TXD        = txdReg;
  assign TX_BUSY    = (state != IDLE) || (count != '0);
  assign FIFO_FULL  = (count == 3'd4);
  assign FIFO_COUNT = count;
  assign OVERFLOW   = overflowReg;

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Testbench for rs232_tx_fifo: directed stimulus with a scoreboard queue of
// expected bytes, checked by a serial-line receiver monitor.
module tb_rs232_tx_fifo;

  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] SendData;
  logic       SendDataReady;
  logic       TXD;
  logic       TX_BUSY;
  logic       FIFO_FULL;
  logic [2:0] FIFO_COUNT;
  logic       OVERFLOW;

  logic [7:0] SendData2;
  logic       SendDataReady2;
  logic       TXD2;
  logic       TX_BUSY2;
  logic       FIFO_FULL2;
  logic [2:0] FIFO_COUNT2;
  logic       OVERFLOW2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastEdge = 0;
  int peak = 0;
  int peak2 = 0;
  bit peakClr = 1'b1;
  bit rxAbort = 1'b0;
  logic [7:0] expQ [$];

  rs232_tx_fifo #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .SendData(SendData), .SendDataReady(SendDataReady),
    .TXD(TXD), .TX_BUSY(TX_BUSY), .FIFO_FULL(FIFO_FULL),
    .FIFO_COUNT(FIFO_COUNT), .OVERFLOW(OVERFLOW)
  );

  rs232_tx_fifo dut2 (
    .CLK(CLK), .RST(RST), .SendData(SendData2), .SendDataReady(SendDataReady2),
    .TXD(TXD2), .TX_BUSY(TX_BUSY2), .FIFO_FULL(FIFO_FULL2),
    .FIFO_COUNT(FIFO_COUNT2), .OVERFLOW(OVERFLOW2)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (peakClr) begin
      peak  = 0;
      peak2 = 0;
    end else begin
      if (int'(FIFO_COUNT) > peak) peak = int'(FIFO_COUNT);
      if (int'(FIFO_COUNT2) > peak2) peak2 = int'(FIFO_COUNT2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitUntil(input int n);
    while (cyc < n) step();
  endtask

  task automatic strobe(input logic [7:0] d);
    SendData      = d;
    SendDataReady = 1'b1;
    step();
    SendDataReady = 1'b0;
    lastEdge      = cyc;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (TX_BUSY && n < budget) begin
      step();
      n++;
    end
    chk("idleReached", TX_BUSY, 0);
  endtask

  task automatic rxWait(input int n);
    for (int i = 0; i < n; i++) begin
      if (rxAbort) return;
      @(negedge CLK);
      if (RST) rxAbort = 1'b1;
    end
  endtask

  // Receiver: samples mid-bit, compares each completed frame against the queue.
  initial begin
    logic [7:0] rx;
    logic       sb;
    logic       pb;
    forever begin
      @(negedge CLK);
      if (RST !== 1'b0 || TXD !== 1'b0) continue;
      rxAbort = 1'b0;
      rx      = '0;
      rxWait(CPB / 2);
      sb = TXD;
      for (int b = 0; b < 8; b++) begin
        rxWait(CPB);
        rx[b] = TXD;
      end
      rxWait(CPB);
      pb = TXD;
      if (!rxAbort) begin
        chk("rxStartBit", sb, 0);
        chk("rxStopBit", pb, 1);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rxUnexpected: got 0x%0h expected no byte at cycle %0d", rx, cyc);
        end else begin
          chk("rxByte", rx, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frameA5;
    int k;
    SendData       = '0;
    SendDataReady  = 1'b0;
    SendData2      = '0;
    SendDataReady2 = 1'b0;
    frameA5        = 10'b1_1010_0101_0;

    // Reset state
    repeat (3) step();
    chk("rstTXD", TXD, 1);
    chk("rstBusy", TX_BUSY, 0);
    chk("rstFull", FIFO_FULL, 0);
    chk("rstCount", FIFO_COUNT, 0);
    chk("rstOverflow", OVERFLOW, 0);
    chk("rstTXD2", TXD2, 1);
    RST = 1'b0;
    peakClr = 1'b0;
    step();

    // Single byte 0xA5: exact waveform and busy timing
    expQ.push_back(8'hA5);
    strobe(8'hA5);
    k = lastEdge;
    chk("a5CountAtK", FIFO_COUNT, 1);
    chk("a5TxdAtK", TXD, 1);
    chk("a5BusyAtK", TX_BUSY, 1);
    for (int t = 1; t <= 41; t++) begin
      step();
      if (t == 1) chk("a5CountAtK1", FIFO_COUNT, 0);
      if (t <= 40) chk($sformatf("a5Txd_t%0d", t), TXD, frameA5[(t - 1) / CPB]);
      if (t == 40) chk("a5BusyAtK40", TX_BUSY, 1);
      if (t == 41) chk("a5BusyAtK41", TX_BUSY, 0);
    end
    repeat (3) step();

    // Three consecutive strobes
    peakClr = 1'b1;
    step();
    peakClr = 1'b0;
    expQ.push_back(8'h00);
    expQ.push_back(8'hFF);
    expQ.push_back(8'h3C);
    strobe(8'h00);
    strobe(8'hFF);
    strobe(8'h3C);
    waitIdle(200);
    chk("b2bPeakCount", peak, 2);
    chk("b2bOverflow", OVERFLOW, 0);
    repeat (3) step();

    // Six strobes: fill, overflow, then a write coinciding with a pop
    strobe(8'h01);
    k = lastEdge;
    strobe(8'h02);
    strobe(8'h03);
    strobe(8'h04);
    strobe(8'h05);
    strobe(8'h06);
    for (int b = 1; b <= 5; b++) expQ.push_back(8'(b));
    chk("fillFull", FIFO_FULL, 1);
    chk("fillCount", FIFO_COUNT, 4);
    chk("fillOverflow", OVERFLOW, 1);
    waitUntil(k + 41);
    chk("fullBeforePop", FIFO_FULL, 1);
    chk("txdStopEnd", TXD, 1);
    expQ.push_back(8'h77);
    strobe(8'h77);
    chk("pushPopCount", FIFO_COUNT, 4);
    chk("pushPopOverflow", OVERFLOW, 1);
    chk("pushPopTxdStart", TXD, 0);
    waitIdle(400);
    repeat (3) step();

    // Reset during DATA bit 3 with two bytes queued
    strobe(8'h11);
    k = lastEdge;
    strobe(8'h22);
    strobe(8'h33);
    waitUntil(k + 18);
    chk("preRstCount", FIFO_COUNT, 2);
    RST           = 1'b1;
    SendData      = 8'h99;
    SendDataReady = 1'b1;
    step();
    chk("abortTXD", TXD, 1);
    chk("abortCount", FIFO_COUNT, 0);
    chk("abortBusy", TX_BUSY, 0);
    chk("abortOverflow", OVERFLOW, 0);
    step();
    chk("rstWriteIgnored", FIFO_COUNT, 0);
    RST           = 1'b0;
    SendDataReady = 1'b0;
    step();
    chk("postRstTXD", TXD, 1);
    chk("postRstCount", FIFO_COUNT, 0);
    repeat (5) step();
    expQ.push_back(8'h55);
    strobe(8'h55);
    step();
    chk("latency55", TXD, 0);
    waitIdle(100);
    repeat (3) step();

    // Default-rate instance, upstream cadence of one byte per 6945 cycles
    peakClr = 1'b1;
    step();
    peakClr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SendData2      = 8'(8'hC0 + i);
      SendDataReady2 = 1'b1;
      step();
      SendDataReady2 = 1'b0;
      repeat (6944) step();
    end
    chk("cadenceOverflow", OVERFLOW2, 0);
    chk("cadencePeak", peak2, 1);
    chk("cadenceIdle", TX_BUSY2, 0);

    chk("scoreboardEmpty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
